// File: rtl/bcd_to_bin.sv
// Digit-serial BCD-to-binary converter: accumulates value*10 + digit per accepted
// digit (MSD first) and presents the binary result, significant-digit count and error flags.
module bcd_to_bin #(
    parameter int W     = 64,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_bin,
    output logic [CNT_W-1:0] out_digit_count,
    output logic             out_err_digit,
    output logic             out_err_ovf
);

    typedef enum logic {ACCUM, OUT} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             errd_q, errd_d;
    logic             erro_q, erro_d;
    logic [W-1:0]     res_bin_q, res_bin_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             res_errd_q, res_errd_d;
    logic             res_erro_q, res_erro_d;

    logic             bad_digit;
    logic [3:0]       d_eff;
    logic [W+3:0]     ext;
    logic [W+3:0]     prod;

    always_comb begin
        bad_digit  = (in_digit > 4'd9);
        d_eff      = bad_digit ? 4'd0 : in_digit;
        ext        = {4'b0000, acc_q};
        // acc*10 as (acc<<3)+(acc<<1); the 4 extra bits catch overflow past W
        prod       = (ext << 3) + (ext << 1) + {{W{1'b0}}, d_eff};

        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        errd_d     = errd_q;
        erro_d     = erro_q;
        res_bin_d  = res_bin_q;
        res_cnt_d  = res_cnt_q;
        res_errd_d = res_errd_q;
        res_erro_d = res_erro_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d  = prod[W-1:0];
                    errd_d = errd_q | bad_digit;
                    erro_d = erro_q | (prod[W+3:W] != 4'd0);
                    if ((acc_q != '0) || (d_eff != 4'd0)) begin
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d    = OUT;
                        res_bin_d  = acc_d;
                        res_cnt_d  = cnt_d;
                        res_errd_d = errd_d;
                        res_erro_d = erro_d;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    errd_d  = 1'b0;
                    erro_d  = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            errd_q     <= 1'b0;
            erro_q     <= 1'b0;
            res_bin_q  <= '0;
            res_cnt_q  <= '0;
            res_errd_q <= 1'b0;
            res_erro_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            errd_q     <= errd_d;
            erro_q     <= erro_d;
            res_bin_q  <= res_bin_d;
            res_cnt_q  <= res_cnt_d;
            res_errd_q <= res_errd_d;
            res_erro_q <= res_erro_d;
        end
    end

    assign in_ready        = (state_q == ACCUM);
    assign out_valid       = (state_q == OUT);
    assign out_bin         = res_bin_q;
    assign out_digit_count = res_cnt_q;
    assign out_err_digit   = res_errd_q;
    assign out_err_ovf     = res_erro_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: frames of digits checked every cycle against an arithmetic
// reference (big-integer value, significant-digit count) plus literal pins.
module tb_bcd_to_bin;
    localparam int W     = 64;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_digit = 4'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     out_bin;
    logic [CNT_W-1:0] out_digit_count;
    logic             out_err_digit;
    logic             out_err_ovf;

    bcd_to_bin #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_digit_count(out_digit_count), .out_err_digit(out_err_digit), .out_err_ovf(out_err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     bin;
        logic [CNT_W-1:0] cnt;
        logic             ed;
        logic             eo;
    } exp_t;

    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    logic [3:0] frame_q[$];
    bit         rand_ready = 1'b0;
    bit         ready_force = 1'b1;
    bit         ov_model = 1'b0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: true value as a wide integer, wrapped value, significant digits.
    function automatic exp_t model();
        exp_t         e;
        logic [127:0] big  = '0;
        logic [W-1:0] wrap = '0;
        logic [3:0]   de;
        int           cnt  = 0;
        bit           seen = 1'b0;
        e.ed = 1'b0;
        e.eo = 1'b0;
        foreach (frame_q[i]) begin
            de = (frame_q[i] > 4'd9) ? 4'd0 : frame_q[i];
            if (frame_q[i] > 4'd9) e.ed = 1'b1;
            wrap = wrap * 64'd10 + {60'd0, de};
            if (!e.eo) begin
                big = big * 128'd10 + {124'd0, de};
                if (big > {64'd0, {W{1'b1}}}) e.eo = 1'b1;
            end
            if (seen || de != 4'd0) begin
                seen = 1'b1;
                cnt++;
            end
        end
        e.bin = wrap;
        e.cnt = (cnt > 31) ? 5'd31 : CNT_W'(cnt);
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom) : ready_force;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_bin", out_bin, 0);
            chk("rst_out_cnt", out_digit_count, 0);
            chk("rst_err_digit", out_err_digit, 0);
            chk("rst_err_ovf", out_err_ovf, 0);
            ov_model = 1'b0;
        end else begin
            chk("out_valid", out_valid, ov_model);
            chk("in_ready", in_ready, !ov_model);
            if (ov_model) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got out_valid %0b expected no pending result", out_valid);
                end else begin
                    chk("out_bin", out_bin, exp_q[0].bin);
                    chk("out_digit_count", out_digit_count, exp_q[0].cnt);
                    chk("out_err_digit", out_err_digit, exp_q[0].ed);
                    chk("out_err_ovf", out_err_ovf, exp_q[0].eo);
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (out_ready) ov_model = 1'b0;
            end else if (in_valid && in_last) begin
                ov_model = 1'b1;
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(bit gaps, bit push);
        if (push) exp_q.push_back(model());
        foreach (frame_q[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_digit = 4'($urandom);
                    in_last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_digit = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
            wait_accept();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || ov_model) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_str(string s);
        frame_q.delete();
        for (int i = 0; i < s.len(); i++) frame_q.push_back(4'(s.getc(i) - 8'd48));
    endtask

    task automatic pin(string name, exp_t e, logic [W-1:0] bin, int cnt, bit ed, bit eo);
        chk({name, "_bin"}, e.bin, bin);
        chk({name, "_cnt"}, e.cnt, cnt);
        chk({name, "_ed"}, e.ed, ed);
        chk({name, "_eo"}, e.eo, eo);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        load_str("123");
        pin("lit123", model(), 64'd123, 3, 0, 0);
        send_frame(0, 1);
        drain();

        load_str("007");
        pin("lit007", model(), 64'd7, 1, 0, 0);
        send_frame(1, 1);
        load_str("0");
        pin("lit0", model(), 64'd0, 0, 0, 0);
        send_frame(0, 1);

        load_str("18446744073709551615");
        pin("litmax", model(), {W{1'b1}}, 20, 0, 0);
        send_frame(0, 1);
        load_str("18446744073709551616");
        pin("litovf", model(), 64'd0, 20, 0, 1);
        send_frame(1, 1);

        frame_q.delete();
        frame_q.push_back(4'd4);
        frame_q.push_back(4'hA);
        frame_q.push_back(4'd2);
        pin("litbad", model(), 64'd402, 3, 1, 0);
        send_frame(0, 1);

        frame_q.delete();
        repeat (33) frame_q.push_back(4'd9);
        e = model();
        chk("litsat_cnt", e.cnt, 31);
        chk("litsat_eo", e.eo, 1);
        send_frame(0, 1);
        drain();

        ready_force = 1'b0;
        load_str("56");
        send_frame(0, 1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_bin", out_bin, 56);
            chk("bp_in_ready", in_ready, 0);
        end
        ready_force = 1'b1;
        load_str("9");
        pin("lit9", model(), 64'd9, 1, 0, 0);
        send_frame(0, 1);
        drain();

        load_str("34");
        send_frame(0, 0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_bin", out_bin, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", out_digit_count, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_str("31");
        pin("lit31", model(), 64'd31, 2, 0, 0);
        send_frame(0, 1);
        drain();

        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 35) : $urandom_range(1, 12);
            frame_q.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 15) == 0) frame_q.push_back(4'($urandom_range(10, 15)));
                else if (k < 2 && $urandom_range(0, 2) == 0) frame_q.push_back(4'd0);
                else frame_q.push_back(4'($urandom_range(0, 9)));
            end
            send_frame(1, 1);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule
